instruction_prefetch: RTL and testbench
=======================================

Name: instruction_prefetch

Overview:
- Two-entry line buffer between the pipeline's instruction-fetch port and the instruction cache controller.
- Serves 32-bit instructions to the pipeline from buffered 4-word (16-byte) lines.
- Requests missing lines from the cache.
- Sequentially prefetches the next line while the pipeline consumes the current one.

Parameters:
ADDR_W, 32, address width (pipeline and cache side)
INSTR_W, 32, instruction width; line = 4*INSTR_W bits

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
Address  in  ADDR_W  pipeline fetch address, word aligned (bits[1:0] ignored)
Instruction  out  INSTR_W  instruction at Address, valid when Wait=0
Wait  out  1  1 = Address not yet available, pipeline must hold Address
PreFetchedInstructions  in  4*INSTR_W  line from cache; word i at bits[INSTR_W*i+INSTR_W-1 : INSTR_W*i]
PreFetchedWait  in  1  0 = cache presents requested line this cycle
PreFetchedAddress  out  ADDR_W  line address requested, bits[3:0]=0
PreFetchedRequest  out  1  line request to cache

Behaviour:
- Storage: entries E0/E1, each {valid, tag = addr[ADDR_W-1:4], data[4*INSTR_W-1:0]}; register cur (index of entry last hit).
- Reset (sampled on clock edge with reset=1):
  - both valid=0, cur=0, FSM=IDLE, PreFetchedRequest=0, PreFetchedAddress=0.
  - Outputs while no hit: Wait=1, Instruction=0.
- Hit (combinational): entry valid and tag==Address[ADDR_W-1:4].
  - On hit: Wait=0, Instruction = that entry's word Address[3:2].
  - On miss: Wait=1, Instruction=0.
  - On a hit edge, cur <= hit entry index.
- Cache handshake: PreFetchedRequest and PreFetchedAddress are registered and held stable until an edge where PreFetchedRequest=1 and PreFetchedWait=0.
  - On that edge the line is written into the target entry (valid=1, tag from the request) and the request drops.
  - No abort; an issued request always completes.
- FSM states:
  - IDLE, PreFetchedRequest=0:
    - miss: go to DEMAND; request line Address[ADDR_W-1:4],4'b0; target = entry != cur.
    - else, if the line after cur's line (tag+1, wraps to 0 past the top) is in neither entry: go to PREFETCH; request it; target = entry != cur.
    - otherwise stay in IDLE.
  - DEMAND: on completion, go to IDLE.
  - PREFETCH: on completion, go to IDLE.
    - If the pipeline missed meanwhile on a different line, the IDLE miss rule issues the demand on the following edge.
    - If the missed line equals the prefetch line, it becomes a hit after the fill; no extra request.
- Latency:
  - Fill written on edge N; hit visible after edge N (Wait=0 in cycle N+1).
  - No same-cycle bypass from PreFetchedInstructions.
  - Miss-to-request: request asserted after the first edge where the miss is seen in IDLE.
- Miss and completion on the same edge: the fill wins; the miss is re-evaluated next cycle.
- Reset mid-transaction: request dropped immediately, entries invalidated; any later PreFetchedWait is ignored.
- Address changes while Wait=1 are permitted; hit/miss always tracks the current Address.

Decomposition:
- Shared package:
  - LINE_WORDS=4, LINE_OFFSET_BITS=4.
  - FSM state enum {IDLE, DEMAND, PREFETCH}.
  - Line tag/offset field helpers.
- Sub-module prefetch_line_entry: one valid/tag/data register with compare and word select; instantiated twice.
- The FSM and handshake stay at top level.

Test Plan:
- Reset, then Address=0x0; cache answers PreFetchedWait=0 two cycles after the request.
  - Request addr 0x00 observed.
  - Wait=0 with Instruction=line word0.
  - Prefetch request 0x10 issued next.
- Sequential Address 0x0,0x4,0x8,0xC,0x10,0x14 (advance when Wait=0) with cache memory word k = k.
  - Instruction 0,1,2,3,4,5.
  - No Wait at 0x10 once the prefetch has completed.
- Jump to Address 0x100 during an outstanding 0x10 prefetch.
  - 0x10 completes first.
  - Then request 0x100.
  - Wait=1 until its fill, then Instruction = word at 0x100.
- Miss on the same line being prefetched (Address=0x10 while 0x10 is pending).
  - Single request only.
  - Wait drops the cycle after completion.
- Assert reset while PreFetchedRequest=1.
  - Next cycle PreFetchedRequest=0, Wait=1, Instruction=0.
  - After release, Address 0x0 is refetched.
- Address=0xFFFFFFF0 hit: prefetch requests 0x00000000 (wrap).

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// instruction_prefetch_pkg: line geometry, FSM states and address field helpers
package instruction_prefetch_pkg;
    localparam int LINE_WORDS = 4;
    localparam int LINE_OFFSET_BITS = 4;
    typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;
    function automatic logic [1:0] word_index(input logic [LINE_OFFSET_BITS-1:0] offset);
        return offset[3:2];
    endfunction
endpackage

// File: rtl/instruction_prefetch_if.sv
// instruction_prefetch_if: pipeline fetch port plus cache line request port
interface instruction_prefetch_if
    import instruction_prefetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic [INSTR_W-1:0] Instruction;
    logic Wait;
    logic [LINE_WORDS*INSTR_W-1:0] PreFetchedInstructions;
    logic PreFetchedWait;
    logic [ADDR_W-1:0] PreFetchedAddress;
    logic PreFetchedRequest;
    modport slave (
        input Address, PreFetchedInstructions, PreFetchedWait,
        output Instruction, Wait, PreFetchedAddress, PreFetchedRequest
    );
    modport master (
        output Address, PreFetchedInstructions, PreFetchedWait,
        input Instruction, Wait, PreFetchedAddress, PreFetchedRequest
    );
endinterface

// File: rtl/instruction_prefetch_line_entry.sv
// prefetch_line_entry: one buffered cache line with tag compare and word select
module prefetch_line_entry
    import instruction_prefetch_pkg::*;
#(
    parameter int TAG_W = 28,
    parameter int INSTR_W = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic fill,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [LINE_WORDS*INSTR_W-1:0] fill_data,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [1:0] word,
    output logic valid,
    output logic [TAG_W-1:0] tag,
    output logic hit,
    output logic [INSTR_W-1:0] instr
);
    logic [LINE_WORDS*INSTR_W-1:0] data;
    always_ff @(posedge clock) begin
        if (reset) valid <= 1'b0;
        else if (fill) valid <= 1'b1;
        if (fill) begin
            tag <= fill_tag;
            data <= fill_data;
        end
    end
    assign hit = valid && tag == lookup_tag;
    assign instr = data[INSTR_W*word +: INSTR_W];
endmodule

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: two-line instruction buffer with demand fetch and next-line prefetch
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32
) (
    input logic clock,
    input logic reset,
    instruction_prefetch_if.slave bus
);
    localparam int TAG_W = ADDR_W - LINE_OFFSET_BITS;
    state_t state;
    logic cur, target, any_hit, hit_idx, done, next_present, req;
    logic [1:0] hit, valid, fill;
    logic [TAG_W-1:0] tag [2];
    logic [INSTR_W-1:0] instr [2];
    logic [TAG_W-1:0] addr_tag, next_tag, req_tag;
    assign addr_tag = bus.Address[ADDR_W-1:LINE_OFFSET_BITS];
    assign done = req && !bus.PreFetchedWait;
    for (genvar e = 0; e < 2; e++) begin : g_entry
        assign fill[e] = done && target == 1'(e);
        prefetch_line_entry #(.TAG_W(TAG_W), .INSTR_W(INSTR_W)) u_entry (
            .clock(clock),
            .reset(reset),
            .fill(fill[e]),
            .fill_tag(req_tag),
            .fill_data(bus.PreFetchedInstructions),
            .lookup_tag(addr_tag),
            .word(word_index(bus.Address[LINE_OFFSET_BITS-1:0])),
            .valid(valid[e]),
            .tag(tag[e]),
            .hit(hit[e]),
            .instr(instr[e])
        );
    end
    assign any_hit = |hit;
    assign hit_idx = hit[1];
    // next-line candidate follows the line being hit now, i.e. the entry that becomes cur
    assign next_tag = tag[hit_idx] + TAG_W'(1);
    assign next_present = (valid[0] && tag[0] == next_tag) || (valid[1] && tag[1] == next_tag);
    assign bus.Wait = !any_hit;
    assign bus.Instruction = any_hit ? instr[hit_idx] : '0;
    assign bus.PreFetchedRequest = req;
    assign bus.PreFetchedAddress = {req_tag, LINE_OFFSET_BITS'(0)};
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cur <= 1'b0;
            target <= 1'b0;
            req <= 1'b0;
            req_tag <= '0;
        end else begin
            if (any_hit) cur <= hit_idx;
            case (state)
                IDLE: begin
                    if (!any_hit) begin
                        state <= DEMAND;
                        req <= 1'b1;
                        req_tag <= addr_tag;
                        target <= !cur;
                    end else if (!next_present) begin
                        state <= PREFETCH;
                        req <= 1'b1;
                        req_tag <= next_tag;
                        target <= !hit_idx;
                    end
                end
                default: begin
                    if (done) begin
                        state <= IDLE;
                        req <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_prefetch.sv
// tb_instruction_prefetch: directed scenarios plus random fetch streams against a line-buffer model
module tb_instruction_prefetch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    instruction_prefetch_if bus ();
    instruction_prefetch dut (.clock(clock), .reset(reset), .bus(bus));

    int tests = 0, fails = 0, cyc = 0, done_cyc = -10, cnt = 0, lat = 2;
    bit rand_lat = 0, chk = 0;
    bit m_v [2];
    logic [27:0] m_t [2];
    logic [27:0] m_rt;
    int m_cur, m_tgt;
    bit m_busy;
    logic [31:0] bases [5] = '{32'h0, 32'h10, 32'h30, 32'h100, 32'hFFFFFFE0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {2'b0, a[31:2]};
    endfunction

    function automatic logic [127:0] line(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = mem({a[31:4], 4'b0} + 32'(4*i));
        return l;
    endfunction

    function automatic int m_lookup(input logic [27:0] t);
        for (int i = 0; i < 2; i++) if (m_v[i] && m_t[i] == t) return i;
        return -1;
    endfunction

    task automatic m_step();
        int h;
        logic [27:0] nt;
        if (reset) begin
            m_v = '{0, 0};
            m_cur = 0;
            m_busy = 0;
            m_rt = '0;
            return;
        end
        h = m_lookup(bus.Address[31:4]);
        if (m_busy) begin
            if (!bus.PreFetchedWait) begin
                m_v[m_tgt] = 1;
                m_t[m_tgt] = m_rt;
                m_busy = 0;
            end
        end else if (h < 0) begin
            m_busy = 1;
            m_rt = bus.Address[31:4];
            m_tgt = 1 - m_cur;
        end else begin
            nt = m_t[h] + 28'd1;
            if (m_lookup(nt) < 0) begin
                m_busy = 1;
                m_rt = nt;
                m_tgt = 1 - h;
            end
        end
        if (h >= 0) m_cur = h;
    endtask

    task automatic tick();
        if (bus.PreFetchedRequest) begin
            if (cnt == 0 && rand_lat) lat = $urandom_range(0, 3);
            bus.PreFetchedWait = (cnt != lat);
            cnt++;
        end else begin
            cnt = 0;
            bus.PreFetchedWait = 1'($urandom_range(0, 1));
        end
        bus.PreFetchedInstructions = bus.PreFetchedWait ? {$urandom, $urandom, $urandom, $urandom}
                                                        : line(bus.PreFetchedAddress);
        if (bus.PreFetchedRequest && !bus.PreFetchedWait) done_cyc = cyc;
        #1;
        if (chk) begin
            int h;
            h = m_lookup(bus.Address[31:4]);
            check("wait", bus.Wait, 32'(h < 0));
            check("instr", bus.Instruction, h < 0 ? 32'h0 : mem(bus.Address));
            check("req", bus.PreFetchedRequest, 32'(m_busy));
            check("req_addr", bus.PreFetchedAddress, {m_rt, 4'b0});
        end
        @(posedge clock);
        m_step();
        chk = 1;
        cyc++;
        @(negedge clock);
    endtask

    task automatic set_addr(input logic [31:0] a);
        bus.Address = a;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.Wait && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, bus.Wait, 0);
    endtask

    task automatic wait_new_req(input string tag, input logic [31:0] exp);
        int n = 0;
        while (bus.PreFetchedRequest && n < 40) begin
            tick();
            n++;
        end
        while (!bus.PreFetchedRequest && n < 80) begin
            tick();
            n++;
        end
        check({tag, "_req"}, bus.PreFetchedRequest, 1);
        check({tag, "_addr"}, bus.PreFetchedAddress, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rises;
        bit prev;
        int r;
        logic [31:0] a;
        bus.Address = '0;
        bus.PreFetchedWait = 1'b1;
        bus.PreFetchedInstructions = '0;
        @(negedge clock);
        do_reset(2);
        wait_new_req("t1_demand", 32'h0);
        wait_ready("t1");
        check("t1_word0", bus.Instruction, 32'h0);
        wait_new_req("t1_pf", 32'h10);
        for (int k = 0; k < 6; k++) begin
            set_addr(32'(4*k));
            if (k == 4) check("t2_nowait", bus.Wait, 0);
            wait_ready("t2");
            check("t2_instr", bus.Instruction, 32'(k));
            tick();
            if (k == 3) repeat (6) tick();
        end
        lat = 1;
        do_reset(1);
        set_addr(32'h0);
        wait_ready("t3_first");
        wait_new_req("t3_pf", 32'h10);
        set_addr(32'h100);
        wait_new_req("t3_jump", 32'h100);
        wait_ready("t3");
        check("t3_instr", bus.Instruction, 32'h40);
        lat = 2;
        do_reset(1);
        set_addr(32'h0);
        wait_ready("t4_first");
        wait_new_req("t4_pf", 32'h10);
        set_addr(32'h10);
        rises = 0;
        prev = 1;
        for (int n = 0; n < 40 && bus.Wait; n++) begin
            tick();
            if (bus.PreFetchedRequest && !prev) rises++;
            prev = bus.PreFetchedRequest;
        end
        check("t4_single_req", 32'(rises), 0);
        check("t4_wait_latency", 32'(cyc - done_cyc), 1);
        check("t4_instr", bus.Instruction, 32'h4);
        lat = 10;
        set_addr(32'h200);
        wait_new_req("t5", 32'h200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_req", bus.PreFetchedRequest, 0);
        check("t5_rst_wait", bus.Wait, 1);
        check("t5_rst_instr", bus.Instruction, 0);
        lat = 1;
        set_addr(32'h0);
        wait_new_req("t5_refetch", 32'h0);
        do_reset(1);
        set_addr(32'hFFFFFFF0);
        wait_new_req("t6", 32'hFFFFFFF0);
        wait_ready("t6");
        check("t6_instr", bus.Instruction, 32'h3FFFFFFC);
        wait_new_req("t6_wrap", 32'h0);
        rand_lat = 1;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                a = bus.Address;
                if (!bus.Wait && r < 70) a = a + 32'd4;
                else if (r >= 85 || (!bus.Wait && r >= 70))
                    a = bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 31));
                set_addr(a);
                tick();
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
